regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Register-file scoreboard and write-port arbiter for the RISC-V core. It tracks which architectural registers have a result in flight and holds off issue of any instruction that reads or rewrites one of them. It also arbitrates the ALU and load-unit writeback streams onto the single register-file write port (RegWrite/wr/wd). It sits between decode/issue and the register file.

## Interface
Parameters:
- NREG, 32, number of architectural registers; index 0 is hard-wired zero.
- XLEN, 32, data width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; clears all busy bits.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1, issue_rs2  in  5  source register indices.
- issue_rd  in  5  destination register index.
- issue_rd_we  in  1  instruction writes issue_rd.
- issue_ready  out  1  instruction may issue this cycle (combinational).
- wb0_valid, wb0_rd, wb0_data  in  1/5/XLEN  ALU writeback request.
- wb0_ready  out  1  ALU request granted this cycle.
- wb1_valid, wb1_rd, wb1_data  in  1/5/XLEN  load writeback request.
- wb1_ready  out  1  load request granted this cycle.
- rf_we, rf_wr, rf_wd  out  1/5/XLEN  register-file write port (registered).
- busy  out  NREG  busy vector; bit 0 is always 0.
- stall_cnt  out  CNT_W  saturating count of stalled issue cycles.

## Operation
- **Hazard rule.**
  - issue_ready = !flush && !busy[rs1] && !busy[rs2] && !(issue_rd_we && busy[rd]).
  - The check uses registered busy bits only; there is no same-cycle bypass.
- **Issue fire** = issue_valid && issue_ready.
  - If issue_rd_we && rd≠0, set busy[rd] at the edge.
  - rd=0 never sets a busy bit.
- **Arbitration.** The arbiter is 2-way round-robin with one priority pointer bit, initial value 0 (wb0 first).
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester named by the pointer, then toggle the pointer.
  - Single-requester grants leave the pointer unchanged.
- **Grant in cycle T.** The granted rd/data are registered, so rf_we=1 with rf_wr/rf_wd valid during T+1.
  - A grant with rd=0 produces rf_we=0.
- **Busy clear.** busy[rf_wr] clears at the edge ending T+1, so the write has landed in the register file before any dependent read.
  - The earliest dependent issue_ready is cycle T+2.
- **Set/clear collision.** Set requires the bit to be clear and clear requires it to be set, so the two never collide. If an implementation does see both on the same bit, set wins.
- **flush.**
  - issue_ready=0 for that cycle.
  - All busy bits clear at the edge.
  - Writeback grants and the registered write in flight still complete; their clears become no-ops.
- **stall_cnt** increments on issue_valid && !issue_ready && !flush and saturates at all-ones.
- Requesters hold valid/rd/data stable until ready.

## Timing
- **Reset values:**
  - busy=0, rf_we=0, rf_wr=0, rf_wd=0, stall_cnt=0, pointer=0.
  - issue_ready follows combinationally from the cleared state.
- **Reset assertion mid-operation:** the pending registered write is dropped (rf_we=0 immediately) and all busy bits clear.
- **Latencies:**
  - issue_ready and wbX_ready are combinational.
  - Grant to rf_we: 1 cycle.
  - Grant to busy clear: 2 edges.
- **Throughput:** one register-file write per cycle; back-to-back grants give rf_we high on consecutive cycles.

## Structure
- Shared package `core_pkg`: REG_IDX_W=5, NREG, XLEN, and a wb_req struct {valid, rd, data}.
- One sub-module, `rr_arb2`: 2-input round-robin arbiter with valid inputs, grant outputs and the pointer flop.
- Busy vector, hazard logic, write-port register and counter live in the top module.

## Test plan
- **Reset:** rst_n low mid-stream → busy=0, rf_we=0, stall_cnt=0 asynchronously.
- **Issue set/stall:** issue rd=5 → busy[5]=1. Next instruction rs1=5 → issue_ready=0 and stall_cnt increments. wb0 rd=5 data=0x4 granted at T → rf_we=1, rf_wr=5, rf_wd=0x4 at T+1; issue_ready=1 at T+2.
- **x0:** issue rd=0 → busy stays 0. wb1 rd=0 → wb1_ready=1, rf_we=0.
- **Contention:** wb0 and wb1 both valid for 4 cycles → grants alternate wb0, wb1, wb0, wb1. rf_wr sequence matches, one per cycle.
- **WAW:** busy[7]=1, issue rd=7 with no source hazard → stalled until the clear; then issue fires and busy[7]=1 again.
- **Flush and counter:**
  - flush with busy[3]=busy[9]=1 and a wb pending → busy=0 next cycle, pending write still appears on rf_*.
  - Forced 2^CNT_W+5 stall cycles → stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: register index width, register count, datapath
// width, and the writeback request bundle used by the scoreboard.
package core_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NREG      = 32;
   localparam int XLEN      = 32;

   // One writeback request (or one registered register-file write).
   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a single priority pointer bit.
// The pointer names the requester that wins when both ask (0 -> req0).
// The pointer only moves on a contended cycle, so a lone requester never
// steals the other's next turn.
//
// Handshake: a requester raises req and holds it until its gnt is seen
// high in the same cycle; gnt is purely combinational from req and the
// pointer flop.
module rr_arb2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req0_i,
   input  logic req1_i,
   output logic gnt0_o,
   output logic gnt1_o,
   output logic ptr_o
);

   logic ptr_q, ptr_d;

   // Grant selection and pointer update.
   always_comb begin
      gnt0_o = req0_i && (!req1_i || !ptr_q);
      gnt1_o = req1_i && (!req0_i ||  ptr_q);
      ptr_d  = ptr_q;
      if (req0_i && req1_i) begin
         ptr_d = ~ptr_q;
      end
   end

   // Pointer register; wb0 has priority out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard and write-port arbiter.
// Tracks architectural registers with a result in flight (busy vector),
// holds off issue on RAW/WAW hazards, and merges the ALU (wb0) and load
// (wb1) writeback streams onto the single registered register-file write
// port.
//
// Handshakes: issue fires when issue_valid && issue_ready; a writeback
// request transfers when wbX_valid && wbX_ready. Ready signals are
// combinational; requesters hold valid/rd/data stable until ready.
module regfile_scoreboard #(
   parameter int NREG  = core_pkg::NREG,
   parameter int XLEN  = core_pkg::XLEN,
   parameter int CNT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          issue_valid,
   input  logic [core_pkg::REG_IDX_W-1:0] issue_rs1,
   input  logic [core_pkg::REG_IDX_W-1:0] issue_rs2,
   input  logic [core_pkg::REG_IDX_W-1:0] issue_rd,
   input  logic                          issue_rd_we,
   output logic                          issue_ready,
   input  logic                          wb0_valid,
   input  logic [core_pkg::REG_IDX_W-1:0] wb0_rd,
   input  logic [XLEN-1:0]               wb0_data,
   output logic                          wb0_ready,
   input  logic                          wb1_valid,
   input  logic [core_pkg::REG_IDX_W-1:0] wb1_rd,
   input  logic [XLEN-1:0]               wb1_data,
   output logic                          wb1_ready,
   output logic                          rf_we,
   output logic [core_pkg::REG_IDX_W-1:0] rf_wr,
   output logic [XLEN-1:0]               rf_wd,
   output logic [NREG-1:0]               busy,
   output logic [CNT_W-1:0]              stall_cnt
);

   import core_pkg::*;

   logic [NREG-1:0]  busy_q, busy_d;
   logic [NREG-1:0]  set_vec, clr_vec;
   wb_req_t          wr_q, wr_d;
   wb_req_t          req0, req1, sel;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             issue_fire;
   logic             stall_inc;
   logic             gnt0, gnt1;
   logic             arb_ptr;

   // Pack the two writeback streams into request bundles.
   always_comb begin
      req0 = '{valid: wb0_valid, rd: wb0_rd, data: wb0_data};
      req1 = '{valid: wb1_valid, rd: wb1_rd, data: wb1_data};
   end

   rr_arb2 u_arb (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .req0_i (req0.valid),
      .req1_i (req1.valid),
      .gnt0_o (gnt0),
      .gnt1_o (gnt1),
      .ptr_o  (arb_ptr)
   );

   // Hazard check against registered busy bits only (no same-cycle bypass).
   always_comb begin
      issue_ready = !flush
                    && !busy_q[issue_rs1]
                    && !busy_q[issue_rs2]
                    && !(issue_rd_we && busy_q[issue_rd]);
      issue_fire  = issue_valid && issue_ready;
   end

   // Busy next state: clear on the landed write, set on issue (set wins),
   // flush wipes everything, x0 is never busy.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (issue_fire && issue_rd_we && (issue_rd != '0)) begin
         set_vec[issue_rd] = 1'b1;
      end
      if (wr_q.valid) begin
         clr_vec[wr_q.rd] = 1'b1;
      end
      if (flush) begin
         busy_d = '0;
      end else begin
         busy_d = (busy_q & ~clr_vec) | set_vec;
      end
      busy_d[0] = 1'b0;
   end

   // Write-port next state: capture the granted request; a grant to x0 is
   // accepted but produces no write. Address/data hold when idle.
   always_comb begin
      sel        = gnt1 ? req1 : req0;
      wr_d       = wr_q;
      wr_d.valid = 1'b0;
      if ((gnt0 || gnt1) && (sel.rd != '0)) begin
         wr_d.valid = 1'b1;
         wr_d.rd    = sel.rd;
         wr_d.data  = sel.data;
      end
   end

   // Stall counter next state: count refused issue attempts, saturating.
   always_comb begin
      stall_inc = issue_valid && !issue_ready && !flush;
      stall_d   = stall_q;
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   // State registers; reset drops any pending write and clears busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         wr_q    <= '0;
         stall_q <= '0;
      end else begin
         busy_q  <= busy_d;
         wr_q    <= wr_d;
         stall_q <= stall_d;
      end
   end

   assign wb0_ready = gnt0;
   assign wb1_ready = gnt1;
   assign rf_we     = wr_q.valid;
   assign rf_wr     = wr_q.rd;
   assign rf_wd     = wr_q.data;
   assign busy      = busy_q;
   assign stall_cnt = stall_q;

   // The pointer is kept visible for debug probing of arbitration order.
   logic unused_ptr;
   assign unused_ptr = arb_ptr;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: hazard stall/release, x0 handling,
// writeback contention, WAW, flush, counter saturation and async reset.
module tb_regfile_scoreboard;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int CNT_W = 16;

   logic            clk, rst_n, flush;
   logic            issue_valid, issue_rd_we, issue_ready;
   logic [4:0]      issue_rs1, issue_rs2, issue_rd;
   logic            wb0_valid, wb0_ready, wb1_valid, wb1_ready;
   logic [4:0]      wb0_rd, wb1_rd;
   logic [XLEN-1:0] wb0_data, wb1_data;
   logic            rf_we;
   logic [4:0]      rf_wr;
   logic [XLEN-1:0] rf_wd;
   logic [NREG-1:0] busy;
   logic [CNT_W-1:0] stall_cnt;

   int vectors     = 0;
   int miscompares = 0;

   regfile_scoreboard #(.NREG(NREG), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_ready(issue_ready),
      .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd), .busy(busy), .stall_cnt(stall_cnt)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0;
      issue_valid = 1'b0; issue_rd_we = 1'b0;
      issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
      wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we);
      issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2;
      issue_rd = rd; issue_rd_we = we;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      #3;
      vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL reset_busy: got %h expected %h", busy, 32'h0); end
      vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
      vectors++; if (rf_wr !== 5'd0) begin miscompares++; $display("FAIL reset_rf_wr: got %0d expected 0", rf_wr); end
      vectors++; if (rf_wd !== 32'h0) begin miscompares++; $display("FAIL reset_rf_wd: got %h expected 0", rf_wd); end
      vectors++; if (stall_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_stall: got %h expected 0", stall_cnt); end
      vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", issue_ready); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_issue_stall();
      issue(5'd0, 5'd0, 5'd5, 1'b1);
      #1;
      vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL set_ready: got %b expected 1", issue_ready); end
      tick();
      vectors++; if (busy !== 32'h20) begin miscompares++; $display("FAIL set_busy5: got %h expected %h", busy, 32'h20); end
      issue(5'd5, 5'd0, 5'd6, 1'b1);
      #1;
      vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL raw_ready: got %b expected 0", issue_ready); end
      tick();
      vectors++; if (stall_cnt !== 16'd1) begin miscompares++; $display("FAIL raw_stall1: got %0d expected 1", stall_cnt); end
      // cycle T: wb0 writes r5
      idle();
      wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'h4;
      #1;
      vectors++; if (wb0_ready !== 1'b1) begin miscompares++; $display("FAIL wb0_grant: got %b expected 1", wb0_ready); end
      tick();
      // cycle T+1: write visible, dependent still held
      wb0_valid = 1'b0;
      issue(5'd5, 5'd0, 5'd6, 1'b1);
      #1;
      vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL wb_rf_we: got %b expected 1", rf_we); end
      vectors++; if (rf_wr !== 5'd5) begin miscompares++; $display("FAIL wb_rf_wr: got %0d expected 5", rf_wr); end
      vectors++; if (rf_wd !== 32'h4) begin miscompares++; $display("FAIL wb_rf_wd: got %h expected 4", rf_wd); end
      vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL t1_ready: got %b expected 0", issue_ready); end
      tick();
      // cycle T+2: released
      vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL t2_ready: got %b expected 1", issue_ready); end
      vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL t2_busy: got %h expected 0", busy); end
      tick();
      idle();
      vectors++; if (busy !== 32'h40) begin miscompares++; $display("FAIL set_busy6: got %h expected %h", busy, 32'h40); end
      wb1_valid = 1'b1; wb1_rd = 5'd6; wb1_data = 32'h6;
      #1;
      vectors++; if (wb1_ready !== 1'b1) begin miscompares++; $display("FAIL wb1_grant: got %b expected 1", wb1_ready); end
      tick();
      idle();
      tick();
      vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL clr_busy6: got %h expected 0", busy); end
      vectors++; if (stall_cnt !== 16'd2) begin miscompares++; $display("FAIL raw_stall2: got %0d expected 2", stall_cnt); end
   endtask

   task automatic test_x0();
      issue(5'd0, 5'd0, 5'd0, 1'b1);
      #1;
      vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL x0_ready: got %b expected 1", issue_ready); end
      tick();
      idle();
      vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL x0_busy: got %h expected 0", busy); end
      wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'hdead;
      #1;
      vectors++; if (wb1_ready !== 1'b1) begin miscompares++; $display("FAIL x0_wb1_ready: got %b expected 1", wb1_ready); end
      tick();
      idle();
      vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL x0_rf_we: got %b expected 0", rf_we); end
   endtask

   task automatic test_contention();
      logic [4:0] n0, n1, exp_rd;
      logic       exp_g1;
      n0 = 5'd10; n1 = 5'd20;
      for (int i = 0; i < 4; i++) begin
         wb0_valid = 1'b1; wb0_rd = n0; wb0_data = 32'(n0) * 3;
         wb1_valid = 1'b1; wb1_rd = n1; wb1_data = 32'(n1) * 3;
         exp_g1 = (i % 2) == 1;
         exp_rd = exp_g1 ? n1 : n0;
         #1;
         vectors++; if (wb0_ready !== !exp_g1) begin miscompares++; $display("FAIL rr_wb0_ready[%0d]: got %b expected %b", i, wb0_ready, !exp_g1); end
         vectors++; if (wb1_ready !== exp_g1) begin miscompares++; $display("FAIL rr_wb1_ready[%0d]: got %b expected %b", i, wb1_ready, exp_g1); end
         tick();
         vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL rr_rf_we[%0d]: got %b expected 1", i, rf_we); end
         vectors++; if (rf_wr !== exp_rd) begin miscompares++; $display("FAIL rr_rf_wr[%0d]: got %0d expected %0d", i, rf_wr, exp_rd); end
         vectors++; if (rf_wd !== 32'(exp_rd) * 3) begin miscompares++; $display("FAIL rr_rf_wd[%0d]: got %h expected %h", i, rf_wd, 32'(exp_rd) * 3); end
         if (exp_g1) n1 = n1 + 5'd1;
         else        n0 = n0 + 5'd1;
      end
      idle();
      tick();
      vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL rr_idle_we: got %b expected 0", rf_we); end
   endtask

   task automatic test_waw();
      issue(5'd0, 5'd0, 5'd7, 1'b1);
      tick();
      idle();
      vectors++; if (busy !== 32'h80) begin miscompares++; $display("FAIL waw_busy7: got %h expected %h", busy, 32'h80); end
      issue(5'd1, 5'd2, 5'd7, 1'b1);
      wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h77;
      #1;
      vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL waw_ready_t: got %b expected 0", issue_ready); end
      vectors++; if (wb0_ready !== 1'b1) begin miscompares++; $display("FAIL waw_wb0_ready: got %b expected 1", wb0_ready); end
      tick();
      wb0_valid = 1'b0;
      #1;
      vectors++; if (rf_wr !== 5'd7 || rf_we !== 1'b1) begin miscompares++; $display("FAIL waw_rf: got we=%b wr=%0d expected we=1 wr=7", rf_we, rf_wr); end
      vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL waw_ready_t1: got %b expected 0", issue_ready); end
      tick();
      vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL waw_ready_t2: got %b expected 1", issue_ready); end
      tick();
      idle();
      vectors++; if (busy !== 32'h80) begin miscompares++; $display("FAIL waw_reset_busy7: got %h expected %h", busy, 32'h80); end
      wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h70;
      tick();
      idle();
      tick();
      vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL waw_clear: got %h expected 0", busy); end
      vectors++; if (stall_cnt !== 16'd4) begin miscompares++; $display("FAIL waw_stall: got %0d expected 4", stall_cnt); end
   endtask

   task automatic test_flush();
      issue(5'd0, 5'd0, 5'd3, 1'b1);
      tick();
      issue(5'd0, 5'd0, 5'd9, 1'b1);
      tick();
      idle();
      vectors++; if (busy !== 32'h208) begin miscompares++; $display("FAIL flush_pre_busy: got %h expected %h", busy, 32'h208); end
      issue(5'd0, 5'd0, 5'd12, 1'b1);
      flush = 1'b1;
      wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h33;
      #1;
      vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %b expected 0", issue_ready); end
      vectors++; if (wb0_ready !== 1'b1) begin miscompares++; $display("FAIL flush_wb0_ready: got %b expected 1", wb0_ready); end
      tick();
      idle();
      #1;
      vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL flush_busy: got %h expected 0", busy); end
      vectors++; if (rf_we !== 1'b1 || rf_wr !== 5'd3 || rf_wd !== 32'h33) begin miscompares++; $display("FAIL flush_write: got we=%b wr=%0d wd=%h expected we=1 wr=3 wd=33", rf_we, rf_wr, rf_wd); end
      vectors++; if (stall_cnt !== 16'd4) begin miscompares++; $display("FAIL flush_stall: got %0d expected 4", stall_cnt); end
      tick();
      vectors++; if (busy !== 32'h0 || rf_we !== 1'b0) begin miscompares++; $display("FAIL flush_after: got busy=%h we=%b expected busy=0 we=0", busy, rf_we); end
   endtask

   task automatic test_saturate();
      issue(5'd0, 5'd0, 5'd15, 1'b1);
      tick();
      issue(5'd15, 5'd0, 5'd0, 1'b0);
      repeat ((1 << CNT_W) + 5) tick();
      vectors++; if (stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_stall: got %h expected ffff", stall_cnt); end
      vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL sat_ready: got %b expected 0", issue_ready); end
   endtask

   task automatic test_midreset();
      idle();
      wb0_valid = 1'b1; wb0_rd = 5'd15; wb0_data = 32'h55;
      wb1_valid = 1'b1; wb1_rd = 5'd16; wb1_data = 32'h66;
      #1;
      vectors++; if (wb0_ready !== 1'b1) begin miscompares++; $display("FAIL mr_pre_grant: got %b expected 1", wb0_ready); end
      tick();
      idle();
      #1;
      vectors++; if (rf_we !== 1'b1 || rf_wr !== 5'd15) begin miscompares++; $display("FAIL mr_pending: got we=%b wr=%0d expected we=1 wr=15", rf_we, rf_wr); end
      rst_n = 1'b0;
      #1;
      vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL mr_rf_we: got %b expected 0", rf_we); end
      vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL mr_busy: got %h expected 0", busy); end
      vectors++; if (stall_cnt !== 16'h0) begin miscompares++; $display("FAIL mr_stall: got %h expected 0", stall_cnt); end
      tick();
      rst_n = 1'b1;
      tick();
      wb0_valid = 1'b1; wb0_rd = 5'd17; wb0_data = 32'h11;
      wb1_valid = 1'b1; wb1_rd = 5'd18; wb1_data = 32'h22;
      #1;
      vectors++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin miscompares++; $display("FAIL mr_ptr: got g0=%b g1=%b expected g0=1 g1=0", wb0_ready, wb1_ready); end
      tick();
      idle();
      vectors++; if (rf_wr !== 5'd17) begin miscompares++; $display("FAIL mr_post_wr: got %0d expected 17", rf_wr); end
   endtask

   initial begin
      test_reset();
      test_issue_stall();
      test_x0();
      test_contention();
      test_waw();
      test_flush();
      test_saturate();
      test_midreset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
